// File: rtl/module_pipe_flops.sv
// Elastic valid/ready register pipeline for the phy_rx datapath: DEPTH stages of WIDTH-bit words.
// Optional upstream-violation counter on drop_cnt is built when PIPE_DROP_CNT_EN is defined.
module module_pipe_flops #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 3,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk_pipe,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ready_in,
  output logic [CNTW-1:0]  occupancy
`ifdef PIPE_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  // Handshake: a word moves across a boundary on a cycle where valid and ready are both high;
  // valid never depends on ready, and ready_out may depend combinationally on ready_in.

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CNTW-1:0]  r_occ;

  logic [DEPTH-1:0] w_en;
  logic [DEPTH-1:0] w_src_v;
  logic [DEPTH-1:0] w_v_nxt;
  logic [WIDTH-1:0] w_src_d [DEPTH];
  logic [CNTW-1:0]  w_pop;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      // Unrolled enable chain: a stage may load when any stage at or after it is empty, or the sink is ready.
      assign w_en[gi] = ready_in | ~(&r_v[DEPTH-1:gi]);
      if (gi == 0) begin : g_head
        assign w_src_v[gi] = valid_in;
        assign w_src_d[gi] = data_in;
      end else begin : g_body
        assign w_src_v[gi] = r_v[gi-1];
        assign w_src_d[gi] = r_d[gi-1];
      end
      assign w_v_nxt[gi] = w_en[gi] ? w_src_v[gi] : r_v[gi];
    end
  endgenerate

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pop = w_pop + CNTW'(w_v_nxt[i]);
    end
  end

  always_ff @(posedge clk_pipe) begin
    if (reset) begin
      r_v   <= '0;
      r_occ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else begin
      r_v   <= w_v_nxt;
      r_occ <= w_pop;
      // Data only moves with a valid word; bubbles leave the old payload in place.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_en[i] && w_src_v[i]) begin
          r_d[i] <= w_src_d[i];
        end
      end
    end
  end

  assign ready_out = w_en[0];
  assign valid_out = r_v[DEPTH-1];
  assign data_out  = r_d[DEPTH-1];
  assign occupancy = r_occ;

`ifdef PIPE_DROP_CNT_EN
  logic [7:0] r_drop;

  always_ff @(posedge clk_pipe) begin
    if (reset) begin
      r_drop <= '0;
    end else if (valid_in && !w_en[0] && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign drop_cnt = r_drop;
`endif

endmodule

// File: tb/tb_module_pipe_flops.sv
// Self-checking bench for module_pipe_flops: directed scenarios plus random traffic against a
// word-position model of the pipe (each in-flight word tracked by its stage index).
module tb_module_pipe_flops;
  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic             clk_pipe = 1'b0;
  logic             reset;
  logic             valid_in;
  logic [WIDTH-1:0] data_in;
  logic             ready_out;
  logic             valid_out;
  logic [WIDTH-1:0] data_out;
  logic             ready_in;
  logic [CNTW-1:0]  occupancy;
`ifdef PIPE_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif

  module_pipe_flops #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_pipe  (clk_pipe),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_in  (ready_in),
    .occupancy (occupancy)
`ifdef PIPE_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk_pipe = ~clk_pipe;

  // ---------------- reference model / scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];   // accepted words, oldest first
  int               m_pos[$];   // stage index of each word in exp_q
  logic [WIDTH-1:0] m_last;     // payload currently parked in the last stage
  int               m_drop;
  bit               m_known;    // model is meaningful only after the first reset edge
  int               tests;
  int               fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance the model at posedge.
  task automatic step(input logic rst, input logic vin, input logic [31:0] din, input logic rdy);
    bit m_ready;
    bit m_vout;
    int n;
    reset    = rst;
    valid_in = vin;
    data_in  = din;
    ready_in = rdy;
    @(negedge clk_pipe);
    n      = exp_q.size();
    m_ready = rdy || (n < DEPTH);
    m_vout  = (n > 0) && (m_pos[0] == DEPTH - 1);
    if (m_known) begin
      chk("ready_out", {31'd0, ready_out}, {31'd0, m_ready});
      chk("valid_out", {31'd0, valid_out}, {31'd0, m_vout});
      chk("data_out", data_out, m_last);
      chk("occupancy", 32'(occupancy), 32'(n));
      if (m_vout) chk("order", data_out, exp_q[0]);
`ifdef PIPE_DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    end
    @(posedge clk_pipe);
    if (rst) begin
      exp_q.delete();
      m_pos.delete();
      m_last  = '0;
      m_drop  = 0;
      m_known = 1'b1;
    end else begin
      if (vin && !m_ready && m_drop < 255) m_drop++;
      // A word advances unless the sink is stalled and every stage ahead of it is occupied.
      for (int k = 0; k < n; k++) begin
        if (m_pos[k] < DEPTH - 1 && (rdy || k < DEPTH - 1 - m_pos[k])) m_pos[k]++;
      end
      if (m_vout && rdy) begin
        void'(m_pos.pop_front());
        void'(exp_q.pop_front());
      end
      if (vin && m_ready) begin
        exp_q.push_back(din);
        m_pos.push_back(0);
      end
      if (m_pos.size() > 0 && m_pos[0] == DEPTH - 1) m_last = exp_q[0];
    end
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    tests   = 0;
    fails   = 0;
    m_known = 1'b0;
    m_last  = '0;
    m_drop  = 0;
    reset = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b0;

    // Reset held two cycles while upstream drives all-ones.
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_ready_out", {31'd0, ready_out}, 32'd1);

    // Back-to-back stream of 1..8, then drain.
    for (int w = 1; w <= 8; w++) begin
      step(1'b0, 1'b1, 32'(w), 1'b1);
      if (w == 3) chk("latency_word1", data_out, 32'd1);
    end
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Fill with A1..A3 under backpressure, then one release cycle with A4.
    step(1'b0, 1'b1, 32'hA1, 1'b0);
    step(1'b0, 1'b1, 32'hA2, 1'b0);
    step(1'b0, 1'b1, 32'hA3, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("full_occupancy", 32'(occupancy), 32'd3);
    chk("full_ready_out", {31'd0, ready_out}, 32'd0);
    chk("full_data_out", data_out, 32'hA1);
    step(1'b0, 1'b1, 32'hA4, 1'b1);
    chk("after_release_data", data_out, 32'hA2);
    chk("after_release_occ", 32'(occupancy), 32'd3);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Bubble collapse: B1, gap, B2 with the sink stalled.
    step(1'b0, 1'b1, 32'hB1, 1'b0);
    step(1'b0, 1'b0, $urandom, 1'b0);
    step(1'b0, 1'b1, 32'hB2, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("bubble_occupancy", 32'(occupancy), 32'd2);
    chk("bubble_head", data_out, 32'hB1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("bubble_second", data_out, 32'hB2);
    chk("bubble_second_valid", {31'd0, valid_out}, 32'd1);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset with a full pipe, then a fresh word C1.
    step(1'b0, 1'b1, 32'hC0DE_0001, 1'b0);
    step(1'b0, 1'b1, 32'hC0DE_0002, 1'b0);
    step(1'b0, 1'b1, 32'hC0DE_0003, 1'b0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("midrst_occupancy", 32'(occupancy), 32'd0);
    chk("midrst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("midrst_data_out", data_out, 32'd0);
    step(1'b0, 1'b1, 32'h0000_00C1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("c1_emerges", data_out, 32'h0000_00C1);
    chk("c1_valid", {31'd0, valid_out}, 32'd1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), $urandom,
           ($urandom_range(0, 2) != 0));
    end

`ifdef PIPE_DROP_CNT_EN
    // Sustained upstream violations must saturate the counter.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < DEPTH + 300; i++) step(1'b0, 1'b1, $urandom, 1'b0);
    chk("drop_saturated", 32'(drop_cnt), 32'd255);
    step(1'b1, 1'b1, 32'h0, 1'b0);
    chk("drop_reset", 32'(drop_cnt), 32'd0);
`endif

    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("final_empty", 32'(occupancy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
